// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles little-endian words from a length-prefixed
// stream and writes them into instruction memory while holding the core in reset.
module imem_loader #(
  parameter int P_DATA_WIDTH  = 32,
  parameter int P_ADDR_WIDTH  = 11,
  parameter int P_DEPTH_WORDS = 256
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_byte_valid,
  input  logic [7:0]              i_byte_data,
  output logic                    o_byte_ready,
  output logic                    o_we,
  output logic [P_ADDR_WIDTH-1:0] o_waddr,
  output logic [P_DATA_WIDTH-1:0] o_wdata,
  output logic                    o_cpu_hold,
  output logic                    o_done,
  output logic                    o_err
);

  localparam int LP_IDX_W = $clog2(P_DEPTH_WORDS) + 1;
  localparam int LP_WA_W  = P_ADDR_WIDTH - 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } t_state;

  t_state                  r_state;
  t_state                  w_next;
  logic                    w_accept;
  logic [15:0]             w_len_full;
  logic [LP_IDX_W-1:0]     w_widx_inc;
  logic [15:0]             r_len;
  logic [LP_IDX_W-1:0]     r_word_idx;
  logic [1:0]              r_byte_idx;
  logic [P_DATA_WIDTH-1:0] r_buf;
  logic                    r_byte_ready;
  logic                    r_we;
  logic [P_ADDR_WIDTH-1:0] r_waddr;
  logic [P_DATA_WIDTH-1:0] r_wdata;
  logic                    r_cpu_hold;
  logic                    r_done;
  logic                    r_err;

  assign o_byte_ready = r_byte_ready;
  assign o_we         = r_we;
  assign o_waddr      = r_waddr;
  assign o_wdata      = r_wdata;
  assign o_cpu_hold   = r_cpu_hold;
  assign o_done       = r_done;
  assign o_err        = r_err;

  // Next-state decode; the length check uses the full 16-bit header value.
  always_comb begin
    w_next     = r_state;
    w_accept   = i_byte_valid & r_byte_ready;
    w_len_full = {i_byte_data, r_len[7:0]};
    w_widx_inc = r_word_idx + LP_IDX_W'(1);
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_LEN_LO;
        else         w_next = S_IDLE;
      end
      S_LEN_LO: begin
        if (w_accept) w_next = S_LEN_HI;
        else          w_next = S_LEN_LO;
      end
      S_LEN_HI: begin
        if (!w_accept) w_next = S_LEN_HI;
        else if ((w_len_full == 16'd0) || (w_len_full > 16'(P_DEPTH_WORDS))) w_next = S_ERR;
        else w_next = S_DATA;
      end
      S_DATA: begin
        if (w_accept && (r_byte_idx == 2'd3)) w_next = S_WRITE;
        else                                  w_next = S_DATA;
      end
      S_WRITE: begin
        if (16'(w_widx_inc) == r_len) w_next = S_DONE;
        else                          w_next = S_DATA;
      end
      S_DONE:  w_next = S_IDLE;
      S_ERR: begin
        if (i_start) w_next = S_LEN_LO;
        else         w_next = S_ERR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Datapath and outputs, registered from the next state so they align with it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_len        <= 16'd0;
      r_word_idx   <= '0;
      r_byte_idx   <= 2'd0;
      r_buf        <= '0;
      r_byte_ready <= 1'b0;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_cpu_hold   <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_byte_ready <= (w_next == S_LEN_LO) || (w_next == S_LEN_HI) || (w_next == S_DATA);
      r_we         <= (w_next == S_WRITE);
      r_done       <= (w_next == S_DONE);
      r_err        <= (w_next == S_ERR);
      if (w_next == S_DONE)      r_cpu_hold <= 1'b0;
      else if (w_next != S_IDLE) r_cpu_hold <= 1'b1;
      else                       r_cpu_hold <= r_cpu_hold;
      case (r_state)
        S_LEN_LO: if (w_accept) r_len[7:0] <= i_byte_data;
        S_LEN_HI: begin
          if (w_accept) begin
            r_len[15:8] <= i_byte_data;
            r_word_idx  <= '0;
            r_byte_idx  <= 2'd0;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_buf      <= {i_byte_data, r_buf[P_DATA_WIDTH-1:8]};
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_wdata <= {i_byte_data, r_buf[P_DATA_WIDTH-1:8]};
              r_waddr <= {LP_WA_W'(r_word_idx), 2'b00};
            end
          end
        end
        S_WRITE: r_word_idx <= w_widx_inc;
        default: r_len <= r_len;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader: a queue of expected (address, word) writes is
// built from each program image and matched against every observed write strobe.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        we;
  logic [10:0] waddr;
  logic [31:0] wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          last_we_cyc = -10;
  int          done_cnt = 0;
  int          loads = 0;
  logic [31:0] wbuf [256];
  int unsigned exp_a [$];
  logic [31:0] exp_d [$];

  imem_loader dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_byte_valid (byte_valid),
    .i_byte_data  (byte_data),
    .o_byte_ready (byte_ready),
    .o_we         (we),
    .o_waddr      (waddr),
    .o_wdata      (wdata),
    .o_cpu_hold   (cpu_hold),
    .o_done       (done),
    .o_err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Scoreboard: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (we) begin
      if (exp_d.size() == 0) chk("unexpected_we", 32'd1, 32'd0);
      else begin
        chk("waddr", {21'd0, waddr}, exp_a.pop_front());
        chk("wdata", wdata, exp_d.pop_front());
      end
      last_we_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      chk("done_latency", cyc, last_we_cyc + 1);
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    bit ok = 1'b0;
    int g = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
    byte_valid = 1'b0;
    repeat (g) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    for (int t = 0; t < 40 && !ok; t++) begin
      if (byte_ready) begin
        @(posedge clk);
        @(negedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic load(input int n, input int gap, input bit mid_start);
    bit seen = 1'b0;
    pulse_start();
    for (int k = 0; k < n; k++) begin
      exp_a.push_back(k * 4);
      exp_d.push_back(wbuf[k]);
    end
    send_byte(8'(n % 256), gap);
    send_byte(8'(n / 256), gap);
    for (int k = 0; k < n; k++) begin
      if (mid_start && k == n / 2) pulse_start();
      for (int b = 0; b < 4; b++) send_byte(8'(wbuf[k] >> (8 * b)), gap);
      chk("we_after_4th_byte", {31'd0, we}, 32'd1);
    end
    for (int t = 0; t < 10 && !seen; t++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("hold_released", {31'd0, cpu_hold}, 32'd0);
    loads++;
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_not_ready", {31'd0, byte_ready}, 32'd0);
    chk("all_writes_seen", exp_d.size(), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; byte_valid = 1'b1; byte_data = 8'h00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = ~start;
      byte_data = 8'($urandom);
      chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
      chk("rst_ready", {31'd0, byte_ready}, 32'd0);
      chk("rst_misc", {we, done, err, 29'd0}, 32'd0);
      chk("rst_waddr_wdata", {21'd0, waddr} | wdata, 32'd0);
    end
    rst = 1'b0; start = 1'b0; byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_after_rst", {31'd0, byte_ready}, 32'd0);

    // Reference program, back-to-back then with random valid gaps.
    wbuf[0] = 32'h00A00513;
    wbuf[1] = 32'h00100593;
    load(2, 0, 1'b0);
    load(2, 5, 1'b0);

    // Invalid headers, then recovery.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("err_n0", {31'd0, err}, 32'd1);
    chk("err_hold", {31'd0, cpu_hold}, 32'd1);
    repeat (3) @(negedge clk);
    chk("err_level", {31'd0, err}, 32'd1);
    chk("err_not_ready", {31'd0, byte_ready}, 32'd0);
    pulse_start();
    chk("err_cleared", {31'd0, err}, 32'd0);
    send_byte(8'h01, 2);
    send_byte(8'h01, 2);
    chk("err_n257", {31'd0, err}, 32'd1);
    wbuf[0] = $urandom;
    load(1, 3, 1'b0);
    chk("err_after_load", {31'd0, err}, 32'd0);

    // Random programs.
    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(8, 1);
      for (int k = 0; k < n; k++) wbuf[k] = $urandom;
      load(n, 5, 1'b0);
    end

    // Full-depth program with a stray start pulse mid-session.
    for (int k = 0; k < 256; k++) wbuf[k] = 32'(k) * 32'h01010101;
    load(256, 0, 1'b1);

    // Reset mid-session, then a fresh load from address 0.
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_hold", {31'd0, cpu_hold}, 32'd1);
    chk("midrst_ready", {31'd0, byte_ready}, 32'd0);
    rst = 1'b0;
    byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_idle", {31'd0, byte_ready}, 32'd0);
    byte_valid = 1'b0;
    wbuf[0] = $urandom;
    load(1, 2, 1'b0);

    repeat (3) @(negedge clk);
    chk("done_total", done_cnt, loads);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
